mem_unit: RTL and testbench
===========================

// Module: mem_unit
// PURPOSE
//  Memory stage driven by the control sequencer's CS/R_NW/load_MAR/load_MDR/MDR_bus strobes.
//  Holds the MAR and MDR registers and a word-addressed RAM array.
//  Runs read and write cycles with a programmable number of wait states.
//  MDR output feeds the system bus, which supplies IR, ACC and PC loads.
// PARAMETERS
//  WORD_W       8  data word width; system bus width
//  ADDR_W       5  address width (WORD_W-OP_W); RAM depth = 2**ADDR_W
//  WAIT_CYCLES  0  extra wait states per access; 0 = single-cycle access
// PORTS
//  clock      in   1       system clock, rising edge
//  n_reset    in   1       asynchronous, active-low reset
//  sysbus     in   WORD_W  system bus value; source for MAR/MDR loads
//  load_MAR   in   1       MAR <= sysbus[ADDR_W-1:0]
//  load_MDR   in   1       MDR <= sysbus
//  MDR_bus    in   1       request to drive MDR onto system bus
//  CS         in   1       access strobe; sampled only in IDLE
//  R_NW       in   1       1 = read, 0 = write; sampled with CS
//  mdr_out    out  WORD_W  MDR contents, continuously driven
//  mdr_drive  out  1       = MDR_bus; bus-mux select
//  mem_busy   out  1       access in progress (WAIT state)
//  mem_done   out  1       one-cycle pulse, the cycle after an access completes
//  parity_err out  1       sticky read-parity error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, MAR=0, MDR=0, wait count=0, mem_busy=0, mem_done=0, parity_err=0.
//   RAM contents are not reset.
//  FSM states:
//   - IDLE: on CS=1 latch R_NW; if WAIT_CYCLES==0 perform the access at this edge, else go to WAIT with cnt=WAIT_CYCLES-1.
//   - WAIT: on cnt==0 perform the access and go to DONE; otherwise cnt--. mem_busy=1 in WAIT.
//   - DONE: mem_done=1 for one cycle, then IDLE. With WAIT_CYCLES==0: IDLE->DONE->IDLE.
//  Access:
//   - Read: MDR <= ram[MAR] at the completing edge, so it is visible on mdr_out the next cycle.
//   - Write: ram[MAR] <= MDR at the completing edge.
//  Latency: with WAIT_CYCLES=0, CS in cycle N gives MDR valid in cycle N+1. This matches the fetch and operand-read timing, where MDR_bus is asserted the cycle after CS.
//  Priority and hazards:
//   - load_MAR while mem_busy: ignored, so the address stays stable for the access.
//   - load_MDR in the same cycle as a read completion: the read wins and load_MDR is dropped.
//   - load_MDR while a write is busy: ignored.
//   - CS while in WAIT or DONE: ignored; no queuing.
//   - load_MAR and load_MDR together in IDLE: both load from the same sysbus value.
//  Address wrap: MAR is ADDR_W bits and upper sysbus bits are discarded, e.g. sysbus 0xE3 -> MAR 5'h03.
//  Reset mid-access: aborts immediately. A pending write is not performed, and MDR is cleared.
// CONFIGURATION
//  Macro MEM_PARITY_EN:
//   - Defined: each RAM word stores WORD_W+1 bits, with an even-parity bit computed from MDR on write.
//     A read that fails parity sets parity_err=1 at the completing edge; it stays set until reset.
//     MDR still loads the data bits.
//   - Undefined: RAM is WORD_W wide and parity_err is tied 0.
// STRUCTURE
//  Package cpu_pkg holds mem_state_t (IDLE, WAIT, DONE) and localparams DEF_WORD_W=8 and DEF_ADDR_W=5.
//  Sub-module mem_array: synchronous write port plus read port (we, addr, wdata, rdata), width WORD_W(+1).
//  mem_unit holds MAR, MDR, the FSM, the wait counter and the parity logic.
// TESTING
//  1. Reset then idle:
//     - mdr_out=0x00, mem_busy=0, mem_done=0, parity_err=0.
//     - Assert n_reset low mid-WAIT: state returns to IDLE at once.
//  2. Write/read, WAIT=0:
//     - Write: sysbus=0x0A + load_MAR; sysbus=0x5C + load_MDR; CS=1,R_NW=0 for 1 cycle.
//     - Read back: load_MAR 0x0A, CS=1,R_NW=1 -> next cycle mdr_out=0x5C, mem_done=1.
//  3. Wait states, WAIT_CYCLES=2:
//     - Read: mem_busy=1 for 2 cycles; mdr_out updates on the completing edge.
//     - mem_done pulses exactly 1 cycle; CS held high during busy starts no second access.
//  4. Hazards:
//     - load_MAR 0x1F during a busy read of 0x03 -> read returns ram[0x03] and MAR stays 0x03.
//     - load_MDR on the read-complete cycle -> MDR holds the RAM data.
//  5. Wrap: sysbus=0xE3 + load_MAR, then read -> ram[0x03] returned.
//  6. MEM_PARITY_EN:
//     - Write 0x01 to 0x04, flip the stored parity bit via hierarchical deposit, then read.
//     - Expect parity_err=1, mdr_out=0x01, and parity_err still 1 after a clean read.
//     - Without the macro, parity_err stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU datapath blocks.
// Holds the memory-stage FSM state type and default widths.
package cpu_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed RAM: synchronous write port, combinational read port.
// Contents are never reset.
module mem_array
  import cpu_pkg::*;
#(
  parameter int DW = DEF_WORD_W,
  parameter int AW = DEF_ADDR_W
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  // Store the write word on the rising edge when enabled
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_unit.sv
// Memory stage: MAR/MDR registers, access FSM with wait states, RAM.
// Optional stored even parity per word under `define MEM_PARITY_EN.
module mem_unit
  import cpu_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] sysbus,
  input  logic              load_MAR,
  input  logic              load_MDR,
  input  logic              MDR_bus,
  input  logic              CS,
  input  logic              R_NW,
  output logic [WORD_W-1:0] mdr_out,
  output logic              mdr_drive,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              parity_err
);

`ifdef MEM_PARITY_EN
  localparam int DW = WORD_W + 1;
`else
  localparam int DW = WORD_W;
`endif

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t        state_q, state_d;
  logic              rnw_q, rnw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q;
  logic [WORD_W-1:0] mdr_q;
  logic              complete;
  logic              acc_rd;
  logic              rd_done;
  logic              wr_done;
  logic              wr_busy;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  // Next-state logic for the access sequencer and wait counter
  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CS) begin
          rnw_d = R_NW;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero-wait access completes in IDLE, before R_NW is latched
  assign acc_rd  = (state_q == IDLE) ? R_NW : rnw_q;
  assign rd_done = complete & acc_rd;
  assign wr_done = complete & ~acc_rd;
  assign wr_busy = (state_q == WAIT) & ~rnw_q;

  // Sequencer state registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      rnw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      cnt_q   <= cnt_d;
    end
  end

  // MAR holds still for the duration of a wait-stated access
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mar_q <= '0;
    end else if (load_MAR && !mem_busy) begin
      mar_q <= sysbus[ADDR_W-1:0];
    end
  end

  // MDR: read data beats a bus load; a pending write keeps its data
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mdr_q <= '0;
    end else if (rd_done) begin
      mdr_q <= rdata[WORD_W-1:0];
    end else if (load_MDR && !wr_busy) begin
      mdr_q <= sysbus;
    end
  end

`ifdef MEM_PARITY_EN
  logic perr_q;

  assign wdata = {^mdr_q, mdr_q};

  // Sticky flag for a stored word whose parity no longer checks
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      perr_q <= 1'b0;
    end else if (rd_done && (^rdata)) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err = perr_q;
`else
  assign wdata      = mdr_q;
  assign parity_err = 1'b0;
`endif

  mem_array #(
    .DW (DW),
    .AW (ADDR_W)
  ) u_array (
    .clock   (clock),
    .we_i    (wr_done),
    .addr_i  (mar_q),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  assign mdr_out   = mdr_q;
  assign mdr_drive = MDR_bus;
  assign mem_busy  = (state_q == WAIT);
  assign mem_done  = (state_q == DONE);

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: a zero-wait and a two-wait-state instance.
// Read expectations come from a RAM model via a scoreboard queue.
module tb_mem_unit;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] sysbus = 8'h00;
  logic       r_nw = 1'b0;
  logic       cs = 1'b0;
  logic       lmar = 1'b0;
  logic       lmdr = 1'b0;
  logic       mbus = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] a_mdr, b_mdr;
  logic       a_drv, b_drv;
  logic       a_busy, b_busy;
  logic       a_done, b_done;
  logic       a_perr, b_perr;

  logic [7:0] mdr;
  logic       drv, busy, done, perr;

  logic [7:0] ram_m [2][32];
  logic [7:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_unit #(.WORD_W(8), .ADDR_W(5), .WAIT_CYCLES(0)) u_a (
    .clock      (clock),
    .n_reset    (n_reset),
    .sysbus     (sysbus),
    .load_MAR   (lmar & ~sel),
    .load_MDR   (lmdr & ~sel),
    .MDR_bus    (mbus & ~sel),
    .CS         (cs & ~sel),
    .R_NW       (r_nw),
    .mdr_out    (a_mdr),
    .mdr_drive  (a_drv),
    .mem_busy   (a_busy),
    .mem_done   (a_done),
    .parity_err (a_perr)
  );

  mem_unit #(.WORD_W(8), .ADDR_W(5), .WAIT_CYCLES(2)) u_b (
    .clock      (clock),
    .n_reset    (n_reset),
    .sysbus     (sysbus),
    .load_MAR   (lmar & sel),
    .load_MDR   (lmdr & sel),
    .MDR_bus    (mbus & sel),
    .CS         (cs & sel),
    .R_NW       (r_nw),
    .mdr_out    (b_mdr),
    .mdr_drive  (b_drv),
    .mem_busy   (b_busy),
    .mem_done   (b_done),
    .parity_err (b_perr)
  );

  assign mdr  = sel ? b_mdr  : a_mdr;
  assign drv  = sel ? b_drv  : a_drv;
  assign busy = sel ? b_busy : a_busy;
  assign done = sel ? b_done : a_done;
  assign perr = sel ? b_perr : a_perr;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 12) begin
      step();
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout sel=%0d got busy=%b want done=1", sel, busy);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int lat;
    sysbus = a; lmar = 1'b1; step(); lmar = 1'b0;
    sysbus = d; lmdr = 1'b1; step(); lmdr = 1'b0;
    cs = 1'b1; r_nw = 1'b0; step(); cs = 1'b0;
    wait_done(lat);
    ram_m[sel][a[4:0]] = d;
    step();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] got,
                         output int lat);
    sysbus = a; lmar = 1'b1; step(); lmar = 1'b0;
    cs = 1'b1; r_nw = 1'b1;
    exp_q.push_back(ram_m[sel][a[4:0]]);
    step(); cs = 1'b0;
    wait_done(lat);
    got = mdr;
    step();
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if ({mdr, busy, done, perr} !== 11'h000) begin
        miscompares++;
        $display("FAIL reset_state sel=%0d got mdr=%h busy=%b done=%b perr=%b want 00/0/0/0",
                 sel, mdr, busy, done, perr);
      end
    end
    n_reset = 1'b1;
    sel = 1'b0;
    step();
  endtask

  task automatic test_rw_nowait();
    logic [7:0] got, e;
    int lat;
    sel = 1'b0;
    do_write(8'h0A, 8'h5C);
    do_read(8'h0A, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || lat !== 1) begin
      miscompares++;
      $display("FAIL rw0_read got=%h lat=%0d want=%h lat=1", got, lat, e);
    end
    mbus = 1'b1; #1;
    vectors++;
    if (drv !== 1'b1) begin
      miscompares++;
      $display("FAIL mdr_drive got=%b want=1", drv);
    end
    mbus = 1'b0; #1;
    vectors++;
    if (drv !== 1'b0) begin
      miscompares++;
      $display("FAIL mdr_drive_off got=%b want=0", drv);
    end
    sysbus = 8'h07; lmar = 1'b1; lmdr = 1'b1; step();
    lmar = 1'b0; lmdr = 1'b0;
    cs = 1'b1; r_nw = 1'b0; step(); cs = 1'b0;
    wait_done(lat); step();
    ram_m[0][7] = 8'h07;
    do_read(8'h07, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL dual_load got=%h want=%h", got, e);
    end
    do_write(8'h0B, 8'h3E);
    sysbus = 8'h0B; lmar = 1'b1; step(); lmar = 1'b0;
    cs = 1'b1; r_nw = 1'b1; lmdr = 1'b1; sysbus = 8'h99;
    exp_q.push_back(ram_m[0][11]);
    step();
    cs = 1'b0; lmdr = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (mdr !== e || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_vs_ldmdr0 got=%h done=%b want=%h done=1", mdr, done, e);
    end
    step();
  endtask

  task automatic test_wait_states();
    logic [7:0] e;
    sel = 1'b1;
    do_write(8'h02, 8'h3C);
    sysbus = 8'hAA; lmdr = 1'b1; step(); lmdr = 1'b0;
    sysbus = 8'h02; lmar = 1'b1; step(); lmar = 1'b0;
    cs = 1'b1; r_nw = 1'b1;
    exp_q.push_back(ram_m[1][2]);
    e = exp_q.pop_front();
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if (busy !== (k < 3) || done !== (k == 3) ||
          mdr !== ((k < 3) ? 8'hAA : e)) begin
        miscompares++;
        $display("FAIL wait_seq k=%0d got busy=%b done=%b mdr=%h want busy=%b done=%b mdr=%h",
                 k, busy, done, mdr, k < 3, k == 3, (k < 3) ? 8'hAA : e);
      end
    end
    cs = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_no_requeue got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_hazards();
    logic [7:0] got, e;
    int lat;
    sel = 1'b1;
    do_write(8'h03, 8'h4D);
    do_write(8'h1F, 8'hF1);
    sysbus = 8'h03; lmar = 1'b1; step(); lmar = 1'b0;
    cs = 1'b1; r_nw = 1'b1;
    exp_q.push_back(ram_m[1][3]);
    step(); cs = 1'b0;
    sysbus = 8'h1F; lmar = 1'b1; step(); lmar = 1'b0;
    sysbus = 8'h77; lmdr = 1'b1; step(); lmdr = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (mdr !== e || done !== 1'b1) begin
      miscompares++;
      $display("FAIL hz_busy_read got=%h done=%b want=%h done=1", mdr, done, e);
    end
    step();
    cs = 1'b1; r_nw = 1'b1;
    exp_q.push_back(ram_m[1][3]);
    step(); cs = 1'b0;
    wait_done(lat);
    e = exp_q.pop_front();
    vectors++;
    if (mdr !== e) begin
      miscompares++;
      $display("FAIL hz_mar_stable got=%h want=%h", mdr, e);
    end
    step();
    sysbus = 8'h05; lmar = 1'b1; step(); lmar = 1'b0;
    sysbus = 8'h21; lmdr = 1'b1; step(); lmdr = 1'b0;
    cs = 1'b1; r_nw = 1'b0; step(); cs = 1'b0;
    sysbus = 8'h66; lmdr = 1'b1; step(); lmdr = 1'b0;
    wait_done(lat);
    ram_m[1][5] = 8'h21;
    vectors++;
    if (mdr !== 8'h21) begin
      miscompares++;
      $display("FAIL hz_wr_ldmdr got=%h want=21", mdr);
    end
    step();
    do_read(8'h05, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || lat !== 3) begin
      miscompares++;
      $display("FAIL hz_wr_data got=%h lat=%0d want=%h lat=3", got, lat, e);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got, e;
    int lat;
    sel = 1'b0;
    do_write(8'h03, 8'h5A);
    do_write(8'h1F, 8'hC7);
    do_read(8'hE3, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wrap_e3 got=%h want=%h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, e;
    int lat;
    sel = 1'b1;
    do_write(8'h08, 8'h11);
    sysbus = 8'h08; lmar = 1'b1; step(); lmar = 1'b0;
    sysbus = 8'h22; lmdr = 1'b1; step(); lmdr = 1'b0;
    cs = 1'b1; r_nw = 1'b0; step(); cs = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy got=%b want=1", busy);
    end
    n_reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || mdr !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset got busy=%b done=%b mdr=%h want 0/0/00",
               busy, done, mdr);
    end
    step(); step();
    n_reset = 1'b1;
    step();
    do_read(8'h08, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL mid_abort got=%h want=%h", got, e);
    end
  endtask

  task automatic test_parity();
`ifdef MEM_PARITY_EN
    logic [7:0] got, e;
    logic [8:0] w;
    int lat;
    sel = 1'b0;
    do_write(8'h04, 8'h01);
    w = u_a.u_array.mem_q[4];
    w[8] = ~w[8];
    u_a.u_array.mem_q[4] = w;
    do_read(8'h04, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || perr !== 1'b1) begin
      miscompares++;
      $display("FAIL par_flip got=%h perr=%b want=%h perr=1", got, perr, e);
    end
    do_read(8'h0A, got, lat);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || perr !== 1'b1) begin
      miscompares++;
      $display("FAIL par_sticky got=%h perr=%b want=%h perr=1", got, perr, e);
    end
`else
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if (perr !== 1'b0) begin
        miscompares++;
        $display("FAIL par_off sel=%0d got=%b want=0", sel, perr);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rw_nowait();
    test_wait_states();
    test_hazards();
    test_wrap();
    test_reset_mid();
    test_parity();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
